// File: rtl/video_timing_gen.sv
// Raster timing source: hsync/vsync/de, pixel coordinates and RGB pulled from an upstream buffer.
// Define VIDEO_TIMING_GEN_TESTPAT_EN to add the pattern_en input and the colour-bar generator.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        data_req,
  input  logic [23:0] data_in,
  input  logic        data_valid,
`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
  input  logic        pattern_en,
`endif
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic [23:0] data_o,
  output logic        frame_start_o,
  output logic        underflow_o,
  output logic        busy_o
);

  localparam int unsigned CW      = 12;
  localparam int unsigned DW      = 24;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          SYNC_ON  = 1'(SYNC_POL);
  localparam logic          SYNC_OFF = ~1'(SYNC_POL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic          busy_q;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;

  logic          running, frame_end, act0, hs0, vs0, fs0, pat0;

  logic          req_q;
  logic          act1_q, hs1_q, vs1_q, fs1_q, pat1_q;
  logic [CW-1:0] x1_q, y1_q;
  logic          act2_q, hs2_q, vs2_q, fs2_q, pat2_q;
  logic [CW-1:0] x2_q, y2_q;

  logic          hsync_q, vsync_q, de_q, fs_q, uf_q;
  logic [CW-1:0] x_q, y_q;
  logic [DW-1:0] data_q, data_d, bar_rgb;
  logic          under_hit, uf_d;

  // Stage-0 decode of the raster position
  always_comb begin
    running   = (state_q != S_IDLE);
    frame_end = (hc_q == H_LAST) && (vc_q == V_LAST);
    act0      = running && (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
    hs0       = running && (hc_q >= HS_FIRST) && (hc_q <= HS_LAST);
    vs0       = running && (vc_q >= VS_FIRST) && (vc_q <= VS_LAST);
    fs0       = act0 && (hc_q == '0) && (vc_q == '0);
  end

  always_comb begin
    hc_d = '0;
    vc_d = '0;
    if (running) begin
      hc_d = (hc_q == H_LAST) ? '0 : hc_q + CW'(1);
      vc_d = vc_q;
      if (hc_q == H_LAST) vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
    end
  end

`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
  localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  logic          pat_q;
  logic [CW-1:0] bar_idx;

  // Pattern selection is latched at pixel (0,0) and holds for the frame
  always_comb begin
    pat0    = fs0 ? pattern_en : pat_q;
    bar_idx = x2_q / CW'(BAR_W);
    case (bar_idx)
      12'd0:   bar_rgb = 24'hFFFFFF;
      12'd1:   bar_rgb = 24'hFFFF00;
      12'd2:   bar_rgb = 24'h00FFFF;
      12'd3:   bar_rgb = 24'h00FF00;
      12'd4:   bar_rgb = 24'hFF00FF;
      12'd5:   bar_rgb = 24'hFF0000;
      12'd6:   bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pat_q <= 1'b0;
    else     pat_q <= pat0;
  end
`else
  assign pat0    = 1'b0;
  assign bar_rgb = '0;
`endif

  // Output stage: merge upstream pixel, blank outside active video
  always_comb begin
    under_hit = act2_q && !pat2_q && !data_valid;
    data_d    = '0;
    if (act2_q) begin
      if (pat2_q)          data_d = bar_rgb;
      else if (data_valid) data_d = data_in;
    end
    uf_d = fs2_q ? under_hit : (uf_q || under_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      req_q   <= 1'b0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      pat1_q  <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      act2_q  <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      fs2_q   <= 1'b0;
      pat2_q  <= 1'b0;
      x2_q    <= '0;
      y2_q    <= '0;
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      // Run control: stopping only ever lands on the last pixel of a frame
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!en) begin
            state_q <= frame_end ? S_IDLE : S_DRAIN;
            busy_q  <= !frame_end;
          end
        end
        S_DRAIN: begin
          if (en) begin
            state_q <= S_RUN;
          end else if (frame_end) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      hc_q <= hc_d;
      vc_q <= vc_d;

      req_q  <= act0 && !pat0;
      act1_q <= act0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
      fs1_q  <= fs0;
      pat1_q <= pat0;
      x1_q   <= act0 ? hc_q : '0;
      y1_q   <= act0 ? vc_q : '0;

      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      fs2_q  <= fs1_q;
      pat2_q <= pat1_q;
      x2_q   <= x1_q;
      y2_q   <= y1_q;

      hsync_q <= hs2_q ? SYNC_ON : SYNC_OFF;
      vsync_q <= vs2_q ? SYNC_ON : SYNC_OFF;
      de_q    <= act2_q;
      x_q     <= x2_q;
      y_q     <= y2_q;
      data_q  <= data_d;
      fs_q    <= fs2_q;
      uf_q    <= uf_d;
    end
  end

  assign data_req      = req_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign pixel_x       = x_q;
  assign pixel_y       = y_q;
  assign data_o        = data_q;
  assign frame_start_o = fs_q;
  assign underflow_o   = uf_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen against a linear-position raster model, small timing set.
module tb_video_timing_gen;

  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FT = HT * VT;
  localparam bit          POL = 1'b0;
  localparam int          M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst, en, data_valid;
  logic [23:0] data_in;
  logic        data_req, hsync_o, vsync_o, de_o, frame_start_o, underflow_o, busy_o;
  logic [11:0] pixel_x, pixel_y;
  logic [23:0] data_o;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .data_req(data_req), .data_in(data_in),
    .data_valid(data_valid), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .data_o(data_o),
    .frame_start_o(frame_start_o), .underflow_o(underflow_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
  } ent_t;

  int unsigned n_chk = 0, n_pass = 0;
  int          m_mode = M_IDLE;
  int          m_pos  = 0;
  ent_t        pipe_q[$];
  logic        e_req, e_busy, e_hs, e_vs, e_de, e_fs, e_uf;
  logic [11:0] e_x, e_y;
  logic [23:0] e_data;
  logic        req_seen = 1'b0;
  logic        meas_arm = 1'b0;
  int          acc_de = 0, acc_hs = 0, acc_vs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    ent_t z;
    z = '0;
    m_mode = M_IDLE;
    m_pos  = 0;
    pipe_q = {z, z};
    e_req = 0; e_busy = 0; e_hs = !POL; e_vs = !POL; e_de = 0; e_fs = 0; e_uf = 0;
    e_x = '0; e_y = '0; e_data = '0;
  endtask

  // One clock edge of the reference: position -> raster attributes, 3-edge delay line
  task automatic model_edge();
    ent_t e, o;
    int   x, y;
    logic miss, last;
    if (rst) begin
      model_reset();
      return;
    end
    e = '0;
    if (m_mode != M_IDLE) begin
      x = m_pos % HT;
      y = m_pos / HT;
      e.act = (x < HA) && (y < VA);
      e.hs  = (x >= HA + HF) && (x < HA + HF + HS);
      e.vs  = (y >= VA + VF) && (y < VA + VF + VS);
      if (e.act) begin
        e.x = 12'(x);
        e.y = 12'(y);
      end
    end
    e_req = e.act;
    pipe_q.push_back(e);
    o = pipe_q.pop_front();
    e_de   = o.act;
    e_x    = o.x;
    e_y    = o.y;
    e_hs   = o.hs ? POL : !POL;
    e_vs   = o.vs ? POL : !POL;
    e_fs   = o.act && (o.x == 0) && (o.y == 0);
    miss   = o.act && !data_valid;
    e_data = (o.act && data_valid) ? data_in : 24'h0;
    e_uf   = e_fs ? miss : (e_uf || miss);
    last   = (m_pos == FT - 1);
    case (m_mode)
      M_IDLE: if (en) begin m_mode = M_RUN; m_pos = 0; end
      M_RUN: begin
        m_pos = (m_pos + 1) % FT;
        if (!en) m_mode = last ? M_IDLE : M_DRAIN;
      end
      default: begin
        m_pos = (m_pos + 1) % FT;
        if (en) m_mode = M_RUN;
        else if (last) m_mode = M_IDLE;
      end
    endcase
    e_busy = (m_mode != M_IDLE);
  endtask

  task automatic compare();
    check("data_req", 32'(data_req), 32'(e_req));
    check("busy", 32'(busy_o), 32'(e_busy));
    check("hsync", 32'(hsync_o), 32'(e_hs));
    check("vsync", 32'(vsync_o), 32'(e_vs));
    check("de", 32'(de_o), 32'(e_de));
    check("pixel_x", 32'(pixel_x), 32'(e_x));
    check("pixel_y", 32'(pixel_y), 32'(e_y));
    check("data", 32'(data_o), 32'(e_data));
    check("frame_start", 32'(frame_start_o), 32'(e_fs));
    check("underflow", 32'(underflow_o), 32'(e_uf));
    if (frame_start_o) begin
      if (meas_arm) begin
        check("de_per_frame", 32'(acc_de), 32'(HA * VA));
        check("hsync_per_frame", 32'(acc_hs), 32'(HS * VT));
        check("vsync_per_frame", 32'(acc_vs), 32'(VS * HT));
      end
      acc_de = 0; acc_hs = 0; acc_vs = 0;
    end
    acc_de += int'(de_o);
    acc_hs += int'(hsync_o == POL);
    acc_vs += int'(vsync_o == POL);
  endtask

  // Upstream returns data the cycle after a request; unrequested cycles carry junk
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    data_in = 24'($urandom);
    if (req_seen) data_valid = ($urandom_range(0, 19) != 0);
    else          data_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    compare();
    req_seen = data_req;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (!(m_mode != M_IDLE && m_pos == p) && n < 3 * int'(FT)) begin
      tick();
      n++;
    end
    check("wait_pos_timeout", 32'(n < 3 * int'(FT)), 32'(1));
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start_o && n < 2 * int'(FT) + 8);
    check("wait_fs_timeout", 32'(frame_start_o), 32'(1));
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; data_valid = 1'b0; data_in = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Start from idle, check latency, then two steady frames
    en = 1'b1;
    wait_fs(n);
    check("fs_latency", 32'(n), 32'(4));
    meas_arm = 1'b1;
    repeat (2 * FT) tick();
    meas_arm = 1'b0;

    // Stop mid-frame: frame completes, then nothing is requested or shown
    wait_pos(3 * HT);
    en = 1'b0;
    repeat (FT) tick();
    check("busy_after_stop", 32'(busy_o), 32'(0));
    repeat (20) tick();

    // Restart, then drop and re-raise en inside the same frame
    en = 1'b1;
    wait_fs(n);
    meas_arm = 1'b1;
    wait_pos(100);
    en = 1'b0;
    repeat (30) tick();
    en = 1'b1;
    wait_fs(n);
    repeat (FT) tick();
    meas_arm = 1'b0;

    // Reset mid-frame, then restart from (0,0)
    wait_pos(2 * HT + 8);
    rst = 1'b1;
    tick();
    check("rst_hsync", 32'(hsync_o), 32'(1));
    check("rst_vsync", 32'(vsync_o), 32'(1));
    rst = 1'b0;
    wait_fs(n);
    check("fs_latency_after_rst", 32'(n), 32'(4));
    meas_arm = 1'b1;
    repeat (FT + 2) tick();
    meas_arm = 1'b0;

    // Random run/stop traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en = !en;
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
